ntt_twiddle_sequencer: RTL and testbench
========================================

NTT_TWIDDLE_SEQUENCER -- requirements
Module: ntt_twiddle_sequencer

Interface
REQ-001 SHALL have parameter TW_FIRST, default 1: twiddle index of the first forward-NTT group; 8-bit.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous assertion, active-low.
REQ-004 SHALL have port start, input, 1: request a transform; sampled only in IDLE.
REQ-005 SHALL have port mode, input, 1: 0 = forward NTT, 1 = inverse NTT; sampled with start.
REQ-006 SHALL have port abort, input, 1: synchronous cancel of a running transform.
REQ-007 SHALL have port bf_ready, input, 1: butterfly unit accepts the current operation.
REQ-008 SHALL have port bf_valid, output, 1: addr_a, addr_b, tw_idx and layer are valid.
REQ-009 SHALL have port addr_a, output, 8: coefficient address of the upper butterfly input.
REQ-010 SHALL have port addr_b, output, 8: coefficient address of the lower butterfly input, equal to addr_a + len.
REQ-011 SHALL have port tw_idx, output, 8: index p driven to the twiddle-factor ROM.
REQ-012 SHALL have port layer, output, 3: current layer, 0..6.
REQ-013 SHALL have port last, output, 1: the current operation is the final butterfly of the transform.
REQ-014 SHALL have port busy, output, 1: high in RUN.
REQ-015 SHALL have port done, output, 1: one-cycle pulse on normal completion.

Function
REQ-016 SHALL implement the states IDLE, RUN and DONE. All outputs SHALL be registered.
REQ-017 In IDLE with start=1, the block SHALL latch mode and enter RUN on the next edge; the first operation SHALL be presented in that first RUN cycle.
REQ-018 In IDLE, start=0 SHALL keep the block in IDLE. In RUN or DONE, start SHALL be ignored.
REQ-019 An operation SHALL advance only on a cycle where bf_valid=1 and bf_ready=1. With bf_ready=0, all outputs SHALL hold stable.
REQ-020 In forward mode, len SHALL equal 128>>layer. The twiddle index k SHALL start at TW_FIRST and increment by 1 per group.
REQ-021 In inverse mode, len SHALL equal 2<<layer. k SHALL start at TW_FIRST+126 and decrement by 1 per group.
REQ-022 Within a layer, the group start address s SHALL step 0, 2*len, 4*len, ... up to 256-2*len.
REQ-023 Within each group, j SHALL step 0..len-1 with addr_a = s+j and tw_idx = k. Each layer SHALL issue exactly 128 operations.
REQ-024 After the final operation of a layer, layer SHALL increment by 1, with s and j reset to 0.
REQ-025 After layer 6 the transform SHALL end; a full transform SHALL be 896 handshakes.
REQ-026 last SHALL be 1 only on operation 896. After its handshake, the block SHALL enter DONE for exactly one cycle (done=1, bf_valid=0, busy=0), then return to IDLE.
REQ-027 abort=1 in RUN SHALL force IDLE on the next edge with no done pulse. abort SHALL take priority over a coincident handshake. abort in IDLE or DONE SHALL have no effect.
REQ-028 All address and index arithmetic SHALL be 8-bit unsigned and never wrap within a legal transform.

Reset
REQ-029 rst_n=0 SHALL immediately force state IDLE and set all outputs to 0, including mid-transform.
REQ-030 After rst_n release, the block SHALL accept start on the first clock edge.

Configuration
REQ-031 Macro NTT_SEQ_INV_EN defined: mode SHALL be honoured per REQ-021.
REQ-032 Macro NTT_SEQ_INV_EN undefined: mode SHALL be ignored, forward sequencing only, and no inverse-mode logic SHALL be synthesised.

Verification
REQ-033 Forward start, bf_ready=1 -> first op addr_a=0, addr_b=128, tw_idx=1, layer=0. Op 129 -> addr_a=0, addr_b=64, tw_idx=2, layer=1. Op 193 -> addr_a=128, addr_b=192, tw_idx=3.
REQ-034 Forward run to completion -> op 896: addr_a=253, addr_b=255, tw_idx=127, layer=6, last=1. done pulses one cycle later; 897 cycles from the first RUN cycle.
REQ-035 Inverse start with NTT_SEQ_INV_EN -> first op addr_a=0, addr_b=2, tw_idx=127. Op 896: addr_a=127, addr_b=255, tw_idx=1, layer=6.
REQ-036 Random bf_ready deassertion -> outputs held stable while stalled. The accepted sequence is identical to the unstalled run, and done follows exactly 896 handshakes.
REQ-037 abort at op 300 -> IDLE next cycle with no done pulse. A new start then begins again at addr_a=0, tw_idx=1.
REQ-038 rst_n low at op 500 -> all outputs 0 immediately. start asserted during RUN -> no effect on the sequence.

Source files
------------

// File: rtl/ntt_twiddle_sequencer.sv
// ntt_twiddle_sequencer
// Address and twiddle-index generator for a 256-point, 7-layer radix-2 NTT.
// Each layer issues 128 butterfly operations over a bf_valid/bf_ready
// handshake. The block presents (addr_a, addr_b = addr_a + len, tw_idx, layer)
// for the current butterfly, and last marks operation 896 of the transform.
//
// Configuration macro: NTT_SEQ_INV_EN
//   defined   : mode=1 selects inverse ordering (len = 2<<layer, k counts
//               down from TW_FIRST+126).
//   undefined : mode is ignored and only forward ordering
//               (len = 128>>layer, k counts up from TW_FIRST) exists.
module ntt_twiddle_sequencer #(
  parameter logic [7:0] TW_FIRST = 8'd1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       mode,
  input  logic       abort,
  input  logic       bf_ready,
  output logic       bf_valid,
  output logic [7:0] addr_a,
  output logic [7:0] addr_b,
  output logic [7:0] tw_idx,
  output logic [2:0] layer,
  output logic       last,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [2:0] LAST_LAYER       = 3'd6;
  localparam logic [6:0] LAST_OP_IN_LAYER = 7'd127;
  localparam logic [7:0] INV_K_OFFSET     = 8'd126;

  // FSM state
  state_e     state_q, state_d;

  // Position within the transform: layer, group start s, offset j within
  // the group, twiddle index k, and operation count within the layer.
  logic [2:0] layer_q, layer_d;
  logic [7:0] s_q, s_d;
  logic [7:0] j_q, j_d;
  logic [7:0] k_q, k_d;
  logic [6:0] cnt_q, cnt_d;

  // Registered outputs
  logic       bf_valid_q, bf_valid_d;
  logic [7:0] addr_a_q, addr_a_d;
  logic [7:0] addr_b_q, addr_b_d;
  logic [7:0] tw_idx_q, tw_idx_d;
  logic       last_q, last_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  // Combinational helpers
  logic [7:0] len_cur;
  logic [7:0] len_nxt;
  logic [7:0] k_next_grp;
  logic       clear;

  // Direction selects: inv_start is the direction being requested with
  // start, inv_run is the direction of the transform in progress.
  logic       inv_start;
  logic       inv_run;

`ifdef NTT_SEQ_INV_EN
  logic       mode_q, mode_d;
  assign inv_start = mode;
  assign inv_run   = mode_q;
`else
  // Forward-only build: direction is tied off so no inverse logic remains.
  logic       unused_mode;
  assign unused_mode = mode;
  assign inv_start   = 1'b0;
  assign inv_run     = 1'b0;
`endif

  // Butterfly span for a given layer and direction.
  function automatic logic [7:0] len_of(input logic [2:0] l, input logic inv);
    return inv ? (8'd2 << l) : (8'd128 >> l);
  endfunction

  // Next-state, next-position and next-output logic.
  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    layer_d    = layer_q;
    s_d        = s_q;
    j_d        = j_q;
    k_d        = k_q;
    cnt_d      = cnt_q;
    bf_valid_d = bf_valid_q;
    addr_a_d   = addr_a_q;
    addr_b_d   = addr_b_q;
    tw_idx_d   = tw_idx_q;
    last_d     = last_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    clear      = 1'b0;
`ifdef NTT_SEQ_INV_EN
    mode_d     = mode_q;
`endif
    len_cur    = len_of(layer_q, inv_run);
    len_nxt    = len_cur;
    k_next_grp = inv_run ? (k_q - 8'd1) : (k_q + 8'd1);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_RUN;
`ifdef NTT_SEQ_INV_EN
          mode_d     = mode;
`endif
          layer_d    = 3'd0;
          s_d        = 8'd0;
          j_d        = 8'd0;
          cnt_d      = 7'd0;
          k_d        = inv_start ? (TW_FIRST + INV_K_OFFSET) : TW_FIRST;
          len_nxt    = len_of(3'd0, inv_start);
          // First operation is presented in the first RUN cycle.
          bf_valid_d = 1'b1;
          busy_d     = 1'b1;
          addr_a_d   = 8'd0;
          addr_b_d   = len_nxt;
          tw_idx_d   = k_d;
          last_d     = 1'b0;
        end
      end

      S_RUN: begin
        if (abort) begin
          // Cancel wins over a coincident handshake; no done pulse.
          state_d = S_IDLE;
          clear   = 1'b1;
        end else if (bf_ready) begin
          if (last_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            clear   = 1'b1;
          end else begin
            cnt_d = cnt_q + 7'd1;
            if (cnt_q == LAST_OP_IN_LAYER) begin
              // Layer finished: move to the next layer, first group.
              layer_d = layer_q + 3'd1;
              s_d     = 8'd0;
              j_d     = 8'd0;
              k_d     = k_next_grp;
            end else if (j_q == (len_cur - 8'd1)) begin
              // Group finished: next group starts 2*len further on.
              s_d = s_q + {len_cur[6:0], 1'b0};
              j_d = 8'd0;
              k_d = k_next_grp;
            end else begin
              j_d = j_q + 8'd1;
            end
            len_nxt  = len_of(layer_d, inv_run);
            addr_a_d = s_d + j_d;
            addr_b_d = s_d + j_d + len_nxt;
            tw_idx_d = k_d;
            last_d   = (layer_d == LAST_LAYER) && (cnt_d == LAST_OP_IN_LAYER);
          end
        end
      end

      S_DONE: begin
        // Single-cycle completion state; start is ignored here.
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        clear   = 1'b1;
      end
    endcase

    // Leaving RUN returns every output and position counter to zero.
    if (clear) begin
      layer_d    = 3'd0;
      s_d        = 8'd0;
      j_d        = 8'd0;
      k_d        = 8'd0;
      cnt_d      = 7'd0;
      bf_valid_d = 1'b0;
      addr_a_d   = 8'd0;
      addr_b_d   = 8'd0;
      tw_idx_d   = 8'd0;
      last_d     = 1'b0;
      busy_d     = 1'b0;
    end
  end

  // State, position and output registers with asynchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      layer_q    <= 3'd0;
      s_q        <= 8'd0;
      j_q        <= 8'd0;
      k_q        <= 8'd0;
      cnt_q      <= 7'd0;
      bf_valid_q <= 1'b0;
      addr_a_q   <= 8'd0;
      addr_b_q   <= 8'd0;
      tw_idx_q   <= 8'd0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      layer_q    <= layer_d;
      s_q        <= s_d;
      j_q        <= j_d;
      k_q        <= k_d;
      cnt_q      <= cnt_d;
      bf_valid_q <= bf_valid_d;
      addr_a_q   <= addr_a_d;
      addr_b_q   <= addr_b_d;
      tw_idx_q   <= tw_idx_d;
      last_q     <= last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

`ifdef NTT_SEQ_INV_EN
  // Direction latched with start for the whole transform.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
    end
  end
`endif

  assign bf_valid = bf_valid_q;
  assign addr_a   = addr_a_q;
  assign addr_b   = addr_b_q;
  assign tw_idx   = tw_idx_q;
  assign layer    = layer_q;
  assign last     = last_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_ntt_twiddle_sequencer.sv
// Self-checking bench for ntt_twiddle_sequencer: directed forward run with
// hand-computed landmarks, stalled run, abort, mid-run reset, and the mode
// input (inverse ordering when NTT_SEQ_INV_EN is defined, ignored otherwise).
module tb_ntt_twiddle_sequencer;

  localparam logic [7:0] TW_FIRST = 8'd1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       mode;
  logic       abort;
  logic       bf_ready;
  logic       bf_valid;
  logic [7:0] addr_a;
  logic [7:0] addr_b;
  logic [7:0] tw_idx;
  logic [2:0] layer;
  logic       last;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ntt_twiddle_sequencer #(
    .TW_FIRST(TW_FIRST)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .mode    (mode),
    .abort   (abort),
    .bf_ready(bf_ready),
    .bf_valid(bf_valid),
    .addr_a  (addr_a),
    .addr_b  (addr_b),
    .tw_idx  (tw_idx),
    .layer   (layer),
    .last    (last),
    .busy    (busy),
    .done    (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // {done, bf_valid, busy, last, layer, tw_idx, addr_a, addr_b}
  function automatic logic [31:0] pack(input logic d, input logic v, input logic b,
                                       input logic l, input logic [2:0] ly,
                                       input logic [7:0] tw, input logic [7:0] a,
                                       input logic [7:0] bb);
    return {1'b0, d, v, b, l, ly, tw, a, bb};
  endfunction

  function automatic logic [31:0] obs();
    return pack(done, bf_valid, busy, last, layer, tw_idx, addr_a, addr_b);
  endfunction

  // Closed-form expectation for operation n (1..896) of a transform.
  function automatic logic [31:0] model_op(input int n, input bit inv);
    int idx, l, o, len, g, j, s, k;
    idx = n - 1;
    l   = idx / 128;
    o   = idx % 128;
    len = inv ? (2 << l) : (128 >> l);
    g   = o / len;
    j   = o % len;
    s   = g * 2 * len;
    if (inv) k = int'(TW_FIRST) + 126 - (128 - (128 >> l)) - g;
    else     k = int'(TW_FIRST) + (1 << l) - 1 + g;
    return pack(1'b0, 1'b1, 1'b1, (n == 896), 3'(l), 8'(k), 8'(s + j), 8'(s + j + len));
  endfunction

  // From a negedge in IDLE: request a transform; returns at the negedge
  // showing operation 1.
  task automatic start_run(input logic m);
    start = 1'b1;
    mode  = m;
    @(negedge clk);
    start = 1'b0;
    mode  = 1'b0;
  endtask

  // With bf_ready=1, check operations from..to, one per cycle.
  task automatic step_ops(input int from, input int to, input bit inv);
    for (int n = from; n <= to; n++) begin
      check($sformatf("op%0d", n), obs(), model_op(n, inv));
      @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  n, hs, cyc;
    bit  r;

    rst_n    = 1'b0;
    start    = 1'b0;
    mode     = 1'b0;
    abort    = 1'b0;
    bf_ready = 1'b1;

    #3;
    check("reset_outputs", obs(), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("idle_no_start", obs(), 32'd0);

    // Full forward transform with hand-computed landmarks.
    start_run(1'b0);
    check("fwd_op1_a", addr_a, 8'd0);
    check("fwd_op1_b", addr_b, 8'd128);
    check("fwd_op1_tw", tw_idx, 8'd1);
    check("fwd_op1_layer", layer, 3'd0);
    check("fwd_op1_busy", {busy, bf_valid, done}, 3'b110);
    step_ops(1, 128, 1'b0);
    check("fwd_op129_a", addr_a, 8'd0);
    check("fwd_op129_b", addr_b, 8'd64);
    check("fwd_op129_tw", tw_idx, 8'd2);
    check("fwd_op129_layer", layer, 3'd1);
    step_ops(129, 192, 1'b0);
    check("fwd_op193_a", addr_a, 8'd128);
    check("fwd_op193_b", addr_b, 8'd192);
    check("fwd_op193_tw", tw_idx, 8'd3);
    step_ops(193, 895, 1'b0);
    check("fwd_op896_a", addr_a, 8'd253);
    check("fwd_op896_b", addr_b, 8'd255);
    check("fwd_op896_tw", tw_idx, 8'd127);
    check("fwd_op896_layer", layer, 3'd6);
    check("fwd_op896_last", last, 1'b1);
    @(negedge clk);
    // Cycle 897 from the first RUN cycle.
    check("fwd_done_pulse", {done, bf_valid, busy}, 3'b100);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("done_to_idle", obs(), 32'd0);
    @(negedge clk);
    check("start_ignored_in_done", obs(), 32'd0);

    // Stalled run with start pulses during RUN.
    start_run(1'b0);
    n   = 1;
    hs  = 0;
    cyc = 0;
    while (!done && cyc < 4000) begin
      check("stall_op", obs(), model_op(n, 1'b0));
      r        = ($urandom_range(0, 3) != 0);
      bf_ready = r;
      start    = (cyc >= 100 && cyc < 110);
      @(negedge clk);
      cyc++;
      if (r) begin
        hs++;
        n++;
      end
    end
    start    = 1'b0;
    bf_ready = 1'b1;
    check("stall_done_seen", done, 1'b1);
    check("stall_handshakes", hs, 896);
    @(negedge clk);

    // Abort at op 300, coincident with a handshake.
    start_run(1'b0);
    step_ops(1, 299, 1'b0);
    check("abort_op300", obs(), model_op(300, 1'b0));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_idle", obs(), 32'd0);
    @(negedge clk);
    check("abort_no_done", obs(), 32'd0);

    // Abort in IDLE has no effect; coincident start is taken.
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    check("restart_op1_a", addr_a, 8'd0);
    check("restart_op1_tw", tw_idx, 8'd1);
    check("restart_op1", obs(), model_op(1, 1'b0));
    @(negedge clk);
    step_ops(2, 499, 1'b0);

    // Asynchronous reset at op 500.
    check("reset_op500", obs(), model_op(500, 1'b0));
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_async", obs(), 32'd0);
    @(negedge clk);
    check("reset_held", obs(), 32'd0);
    rst_n = 1'b1;
    start_run(1'b0);
    check("after_reset_op1", obs(), model_op(1, 1'b0));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("after_reset_abort", obs(), 32'd0);

`ifdef NTT_SEQ_INV_EN
    // Inverse transform.
    start_run(1'b1);
    check("inv_op1_a", addr_a, 8'd0);
    check("inv_op1_b", addr_b, 8'd2);
    check("inv_op1_tw", tw_idx, 8'd127);
    step_ops(1, 895, 1'b1);
    check("inv_op896_a", addr_a, 8'd127);
    check("inv_op896_b", addr_b, 8'd255);
    check("inv_op896_tw", tw_idx, 8'd1);
    check("inv_op896_layer", layer, 3'd6);
    check("inv_op896_last", last, 1'b1);
    @(negedge clk);
    check("inv_done_pulse", {done, bf_valid, busy}, 3'b100);
    @(negedge clk);
`else
    // Forward-only build: mode=1 still yields forward ordering.
    start_run(1'b1);
    check("mode_ignored_a", addr_a, 8'd0);
    check("mode_ignored_b", addr_b, 8'd128);
    check("mode_ignored_tw", tw_idx, 8'd1);
    step_ops(1, 130, 1'b0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("mode_ignored_abort", obs(), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
